// File: rtl/cpu7_icu_pkg.sv
// Shared definitions for the cpu7 instruction-side responder: widths, alignment and FSM encoding.
// The optional line buffer is enabled with the CPU7_ICU_LINEBUF_EN macro.
package cpu7_icu_pkg;

  localparam int ICU_ADDR_W      = 32;
  localparam int ICU_DATA_W      = 64;
  localparam int ICU_ALIGN_SHIFT = 3;
  localparam int ICU_TAG_W       = ICU_ADDR_W - ICU_ALIGN_SHIFT;

  typedef enum logic [2:0] {
    ICU_ST_IDLE  = 3'd0,
    ICU_ST_MREQ  = 3'd1,
    ICU_ST_MWAIT = 3'd2,
    ICU_ST_DRAIN = 3'd3,
    ICU_ST_HIT   = 3'd4
  } icu_state_e;

  function automatic logic [ICU_ADDR_W-1:0] icu_align(input logic [ICU_ADDR_W-1:0] addr);
    return {addr[ICU_ADDR_W-1:ICU_ALIGN_SHIFT], {ICU_ALIGN_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/cpu7_icu_linebuf.sv
// One-entry fetch line buffer: tag, valid bit and doubleword, with hit compare.
// Only instantiated when CPU7_ICU_LINEBUF_EN is defined.
module cpu7_icu_linebuf
  import cpu7_icu_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  inv,
  input  logic                  fill,
  input  logic [ICU_TAG_W-1:0]  fill_tag,
  input  logic [ICU_DATA_W-1:0] fill_data,
  input  logic [ICU_TAG_W-1:0]  lookup_tag,
  output logic                  hit,
  output logic [ICU_DATA_W-1:0] hit_data
);

  logic                  valid_q;
  logic [ICU_TAG_W-1:0]  tag_q;
  logic [ICU_DATA_W-1:0] data_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      if (fill) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag;
        data_q  <= fill_data;
      end
      // Invalidate is applied last so it wins over a fill in the same cycle.
      if (inv) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_data = data_q;

endmodule

// File: rtl/cpu7_icu.sv
// Instruction-side responder: accepts one IFU fetch at a time, reads the aligned doubleword
// from memory and returns it in ic2. Optional line buffer under CPU7_ICU_LINEBUF_EN.
module cpu7_icu
  import cpu7_icu_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  ifu_icu_req_ic1,
  input  logic [ICU_ADDR_W-1:0] ifu_icu_addr_ic1,
  output logic                  icu_ifu_ack_ic1,
  input  logic                  ifu_icu_cancel,
  output logic [ICU_DATA_W-1:0] icu_ifu_data_ic2,
  output logic                  icu_ifu_data_valid_ic2,
  input  logic                  icu_linebuf_inv,
  output logic                  icu_mem_req,
  output logic [ICU_ADDR_W-1:0] icu_mem_addr,
  input  logic                  mem_icu_ack,
  input  logic [ICU_DATA_W-1:0] mem_icu_rdata,
  input  logic                  mem_icu_rvalid,
  output logic [2:0]            dbg_state
);

  // Handshakes: IFU req/ack completes in the cycle both are high (ack only in IDLE, never with
  // cancel); mem req/ack completes when both are high, req holds address until then; rvalid is
  // a single-cycle response per accepted read, and data_valid_ic2 is a single-cycle pulse.

  icu_state_e            state_q, state_d;
  logic                  mem_req_q;
  logic [ICU_ADDR_W-1:0] mem_addr_q;
  logic [ICU_DATA_W-1:0] data_q;
  logic                  valid_q;

  logic                  ack;
  logic                  deliver;
  logic                  hit_take;
  logic                  lb_hit;
  logic [ICU_DATA_W-1:0] lb_data;

  logic [ICU_ALIGN_SHIFT-1:0] unused_addr_lsb;
  assign unused_addr_lsb = ifu_icu_addr_ic1[ICU_ALIGN_SHIFT-1:0];

`ifdef CPU7_ICU_LINEBUF_EN
  cpu7_icu_linebuf u_linebuf (
    .clock      (clock),
    .resetn     (resetn),
    .inv        (icu_linebuf_inv),
    .fill       (deliver),
    .fill_tag   (mem_addr_q[ICU_ADDR_W-1:ICU_ALIGN_SHIFT]),
    .fill_data  (mem_icu_rdata),
    .lookup_tag (ifu_icu_addr_ic1[ICU_ADDR_W-1:ICU_ALIGN_SHIFT]),
    .hit        (lb_hit),
    .hit_data   (lb_data)
  );
`else
  logic unused_linebuf_inv;
  assign unused_linebuf_inv = icu_linebuf_inv;
  assign lb_hit             = 1'b0;
  assign lb_data            = '0;
`endif

  assign ack      = ifu_icu_req_ic1 && (state_q == ICU_ST_IDLE) && !ifu_icu_cancel && resetn;
  assign hit_take = ack && lb_hit;

  always_comb begin
    state_d = state_q;
    deliver = 1'b0;
    case (state_q)
      ICU_ST_IDLE: begin
        if (ack) begin
          state_d = lb_hit ? ICU_ST_HIT : ICU_ST_MREQ;
        end
      end
      ICU_ST_MREQ: begin
        // A cancel racing the memory accept still owes a response, so it must be drained.
        if (mem_icu_ack) begin
          state_d = ifu_icu_cancel ? ICU_ST_DRAIN : ICU_ST_MWAIT;
        end else if (ifu_icu_cancel) begin
          state_d = ICU_ST_IDLE;
        end
      end
      ICU_ST_MWAIT: begin
        if (mem_icu_rvalid) begin
          state_d = ICU_ST_IDLE;
          deliver = !ifu_icu_cancel;
        end else if (ifu_icu_cancel) begin
          state_d = ICU_ST_DRAIN;
        end
      end
      ICU_ST_DRAIN: begin
        if (mem_icu_rvalid) begin
          state_d = ICU_ST_IDLE;
        end
      end
`ifdef CPU7_ICU_LINEBUF_EN
      ICU_ST_HIT: begin
        state_d = ICU_ST_IDLE;
      end
`endif
      default: begin
        state_d = ICU_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= ICU_ST_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == ICU_ST_MREQ);
      if (ack && !lb_hit) begin
        mem_addr_q <= icu_align(ifu_icu_addr_ic1);
      end
      // Hit data is pulsed in the cycle after the ack, so it is registered at the ack.
      valid_q <= deliver || hit_take;
      if (deliver) begin
        data_q <= mem_icu_rdata;
      end else if (hit_take) begin
        data_q <= lb_data;
      end
    end
  end

  assign icu_ifu_ack_ic1        = ack;
  assign icu_ifu_data_ic2       = data_q;
  assign icu_ifu_data_valid_ic2 = valid_q;
  assign icu_mem_req            = mem_req_q;
  assign icu_mem_addr           = mem_addr_q;
  assign dbg_state              = state_q;

endmodule
